// File: rtl/isr_pkg.sv
// Shared constants and command decoding for the input shift register (ISR).
package isr_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // shift_right input encoding
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // One command is executed per enabled cycle; higher value = higher priority.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_IN   = 2'd1,
    CMD_PUSH = 2'd2,
    CMD_MOV  = 2'd3
  } cmd_e;

  // Priority: MOV over PUSH over IN.
  function automatic cmd_e decode_cmd(input logic mov_v, input logic push_v, input logic in_v);
    if (mov_v)       return CMD_MOV;
    else if (push_v) return CMD_PUSH;
    else if (in_v)   return CMD_IN;
    else             return CMD_NONE;
  endfunction

endpackage

// File: rtl/isr_shifter.sv
// Combinational mask/merge datapath: shifts n fresh bits into the ISR.
// n is expected in 1..DATA_W; n == DATA_W replaces the ISR completely.
module isr_shifter
  import isr_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] isr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  n,
  input  logic              shift_right,
  output logic [DATA_W-1:0] next
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] masked;
  logic [CNT_W-1:0]  rshamt;

  // Keep only the low n source bits, then merge them at the end the data enters.
  // Shifts by DATA_W yield zero, so the full-width case needs no special path.
  always_comb begin
    mask   = (n >= FULL) ? '1 : ((DATA_W'(1) << n) - DATA_W'(1));
    masked = in_data & mask;
    rshamt = FULL - n;
    if (shift_right == SHIFT_RIGHT) next = (isr >> n) | (masked << rshamt);
    else                            next = (isr << n) | masked;
  end

endmodule

// File: rtl/isr_autopush.sv
// ISR with bit count, autopush/explicit push to the RX FIFO, MOV load and a
// sticky overflow flag. Push and stall are decided combinationally each cycle.
//
// Handshake: push_valid is only raised while push_ready is high, so a cycle
// with push_valid=1 is a completed FIFO write; a command that needs the FIFO
// while push_ready=0 either stalls (sequencer retries) or drops, never waits.
module isr_autopush
  import isr_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-2:0]  in_count,
  input  logic              shift_right,
  input  logic              autopush_en,
  input  logic [CNT_W-2:0]  push_thresh,
  input  logic              push_cmd,
  input  logic              push_if_full,
  input  logic              push_block,
  input  logic              mov_valid,
  input  logic [DATA_W-1:0] mov_data,
  input  logic              ovf_clr,
  output logic              push_valid,
  output logic [DATA_W-1:0] push_data,
  input  logic              push_ready,
  output logic              stall,
  output logic [DATA_W-1:0] isr_data,
  output logic [CNT_W-1:0]  isr_count,
  output logic              overflow
);

  localparam int               SUM_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DATA_W);
  localparam logic [SUM_W-1:0] FULL_WIDE = SUM_W'(DATA_W);

  logic [DATA_W-1:0] isr_q, isr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  cmd_e              cmd;
  logic [CNT_W-1:0]  n_amt;
  logic [CNT_W-1:0]  thresh;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  new_count;
  logic [DATA_W-1:0] shifted;
  logic              pv, st;
  logic [DATA_W-1:0] pd;

  isr_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .isr         (isr_q),
    .in_data     (in_data),
    .n           (n_amt),
    .shift_right (shift_right),
    .next        (shifted)
  );

  // Decode shift amount, threshold and saturating post-IN count (0 encodes DATA_W).
  always_comb begin
    n_amt  = {1'b0, in_count};
    if (in_count == '0 || n_amt > FULL) n_amt = FULL;
    thresh = {1'b0, push_thresh};
    if (push_thresh == '0 || thresh > FULL) thresh = FULL;
    sum       = {1'b0, count_q} + {1'b0, n_amt};
    new_count = (sum > FULL_WIDE) ? FULL : sum[CNT_W-1:0];
  end

  // Command execution: next state plus the combinational push/stall decision.
  always_comb begin
    isr_d   = isr_q;
    count_d = count_q;
    ovf_d   = (penable && ovf_clr) ? 1'b0 : ovf_q;
    pv      = 1'b0;
    st      = 1'b0;
    pd      = isr_q;
    cmd     = (penable && !reset) ? decode_cmd(mov_valid, push_cmd, in_valid) : CMD_NONE;
    case (cmd)
      CMD_MOV: begin
        isr_d   = mov_data;
        count_d = '0;
      end
      CMD_PUSH: begin
        if (push_if_full && (count_q < thresh)) begin
          // below threshold: no-op
        end else if (push_ready) begin
          pv      = 1'b1;
          pd      = isr_q;
          isr_d   = '0;
          count_d = '0;
        end else if (push_block) begin
          st = 1'b1;
        end else begin
          isr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b1;
        end
      end
      CMD_IN: begin
        if (autopush_en && (new_count >= thresh)) begin
          if (push_ready) begin
            pv      = 1'b1;
            pd      = shifted;
            isr_d   = '0;
            count_d = '0;
          end else begin
            st = 1'b1;
          end
        end else begin
          isr_d   = shifted;
          count_d = new_count;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      isr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      isr_q   <= isr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs read zero throughout reset, even on its first cycle.
  always_comb begin
    push_valid = pv;
    push_data  = pd;
    stall      = st;
    isr_data   = reset ? '0 : isr_q;
    isr_count  = reset ? '0 : count_q;
    overflow   = reset ? 1'b0 : ovf_q;
  end

endmodule

// File: tb/tb_isr_autopush.sv
// Self-checking bench for isr_autopush (DATA_W=32): directed scenarios plus
// randomized commands checked against a behavioural model.
module tb_isr_autopush;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              reset;
  logic              penable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-2:0]  in_count;
  logic              shift_right;
  logic              autopush_en;
  logic [CNT_W-2:0]  push_thresh;
  logic              push_cmd, push_if_full, push_block;
  logic              mov_valid;
  logic [DATA_W-1:0] mov_data;
  logic              ovf_clr;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              stall;
  logic [DATA_W-1:0] isr_data;
  logic [CNT_W-1:0]  isr_count;
  logic              overflow;

  int checks;
  int failures;

  isr_autopush #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .penable(penable),
    .in_valid(in_valid), .in_data(in_data), .in_count(in_count),
    .shift_right(shift_right), .autopush_en(autopush_en), .push_thresh(push_thresh),
    .push_cmd(push_cmd), .push_if_full(push_if_full), .push_block(push_block),
    .mov_valid(mov_valid), .mov_data(mov_data), .ovf_clr(ovf_clr),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .stall(stall), .isr_data(isr_data), .isr_count(isr_count), .overflow(overflow)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    penable = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0;
    shift_right = 1'b0; autopush_en = 1'b0; push_thresh = '0;
    push_cmd = 1'b0; push_if_full = 1'b0; push_block = 1'b0;
    mov_valid = 1'b0; mov_data = '0; ovf_clr = 1'b0; push_ready = 1'b1;
  endtask

  // advance past the next rising edge; inputs may then be changed safely
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_in(input logic [31:0] d, input int n, input logic right);
    drive_idle();
    in_valid = 1'b1; in_data = d; in_count = 5'(n); shift_right = right;
  endtask

  // ---------------- reference model ----------------
  // Shift expressed as a 64-bit concatenation view of {incoming, isr}.
  function automatic logic [31:0] m_shift(input logic [31:0] isr, input logic [31:0] d,
                                          input int n, input logic right);
    logic [63:0] masked;
    logic [63:0] wide;
    masked = (n == 32) ? {32'b0, d} : ({32'b0, d} & ((64'd1 << n) - 64'd1));
    if (right) begin
      wide = {masked[31:0], isr} >> n;
    end else begin
      wide = ({32'b0, isr} << n) | masked;
    end
    return wide[31:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    in_valid = 1'b1; in_count = 5'd8; in_data = 32'hFF;
    push_cmd = 1'b1; push_ready = 1'b0; push_block = 1'b1;
    @(negedge clk);
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (push_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", push_valid); end
    checks++;
    tick();
    @(negedge clk);
    if (isr_data !== 32'h0) begin failures++; $display("FAIL reset_isr got=%h exp=0", isr_data); end
    checks++;
    if (isr_count !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", isr_count); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++;
    tick();
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic test_left_saturate();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_in(32'hA5, 8, 1'b0);
      tick();
      if (i >= 4) begin
        if (isr_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL left_isr_%0d got=%h exp=a5a5a5a5", i, isr_data); end
        checks++;
        if (isr_count !== 6'd32) begin failures++; $display("FAIL left_cnt_%0d got=%0d exp=32", i, isr_count); end
        checks++;
      end
    end
    drive_idle();
  endtask

  task automatic test_right();
    do_reset();
    drive_in(32'hFF, 4, 1'b1);
    tick();
    if (isr_data !== 32'hF0000000) begin failures++; $display("FAIL right_isr got=%h exp=f0000000", isr_data); end
    checks++;
    if (isr_count !== 6'd4) begin failures++; $display("FAIL right_cnt got=%0d exp=4", isr_count); end
    checks++;
    drive_idle();
  endtask

  task automatic test_autopush(input bit stall_first);
    do_reset();
    drive_in(32'h12, 8, 1'b0);
    autopush_en = 1'b1; push_thresh = 5'd16;
    tick();
    drive_in(32'h34, 8, 1'b0);
    autopush_en = 1'b1; push_thresh = 5'd16;
    if (stall_first) begin
      push_ready = 1'b0;
      @(negedge clk);
      if (stall !== 1'b1 || push_valid !== 1'b0) begin
        failures++; $display("FAIL ap_stall got stall=%b pv=%b exp 1/0", stall, push_valid);
      end
      checks++;
      tick();
      if (isr_data !== 32'h12 || isr_count !== 6'd8) begin
        failures++; $display("FAIL ap_hold got isr=%h cnt=%0d exp 12/8", isr_data, isr_count);
      end
      checks++;
      push_ready = 1'b1;
    end
    @(negedge clk);
    if (push_valid !== 1'b1 || push_data !== 32'h00001234 || stall !== 1'b0) begin
      failures++; $display("FAIL ap_push got pv=%b pd=%h st=%b exp 1/00001234/0", push_valid, push_data, stall);
    end
    checks++;
    tick();
    if (isr_data !== 32'h0 || isr_count !== 6'd0) begin
      failures++; $display("FAIL ap_clear got isr=%h cnt=%0d exp 0/0", isr_data, isr_count);
    end
    checks++;
    drive_idle();
  endtask

  task automatic test_nb_push_overflow();
    do_reset();
    drive_in(32'hDEADBEEF, 0, 1'b0);
    tick();
    if (isr_data !== 32'hDEADBEEF || isr_count !== 6'd32) begin
      failures++; $display("FAIL ovf_setup got isr=%h cnt=%0d exp deadbeef/32", isr_data, isr_count);
    end
    checks++;
    drive_idle();
    push_cmd = 1'b1; push_ready = 1'b0;
    @(negedge clk);
    if (push_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL ovf_nopush got pv=%b st=%b exp 0/0", push_valid, stall);
    end
    checks++;
    tick();
    drive_idle();
    if (isr_data !== 32'h0 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_set got isr=%h ovf=%b exp 0/1", isr_data, overflow);
    end
    checks++;
    tick();
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++;
    ovf_clr = 1'b1;
    tick();
    drive_idle();
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_iffull_then_reset();
    do_reset();
    drive_in(32'h5A, 8, 1'b0);
    tick();
    drive_idle();
    push_cmd = 1'b1; push_if_full = 1'b1; push_thresh = 5'd16; push_ready = 1'b1;
    @(negedge clk);
    if (push_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL iffull_noop got pv=%b st=%b exp 0/0", push_valid, stall);
    end
    checks++;
    tick();
    if (isr_data !== 32'h5A || isr_count !== 6'd8) begin
      failures++; $display("FAIL iffull_state got isr=%h cnt=%0d exp 5a/8", isr_data, isr_count);
    end
    checks++;
    drive_idle();
    push_cmd = 1'b1; push_block = 1'b1; push_ready = 1'b0;
    @(negedge clk);
    if (stall !== 1'b1) begin failures++; $display("FAIL block_stall got=%b exp=1", stall); end
    checks++;
    tick();
    reset = 1'b1;
    @(negedge clk);
    if (stall !== 1'b0) begin failures++; $display("FAIL rst_kills_stall got=%b exp=0", stall); end
    checks++;
    tick();
    reset = 1'b0;
    drive_idle();
    if (isr_data !== 32'h0 || isr_count !== 6'd0) begin
      failures++; $display("FAIL rst_after_stall got isr=%h cnt=%0d exp 0/0", isr_data, isr_count);
    end
    checks++;
    // first command right after reset deasserts is accepted
    drive_in(32'h3, 2, 1'b0);
    tick();
    drive_idle();
    if (isr_data !== 32'h3 || isr_count !== 6'd2) begin
      failures++; $display("FAIL first_cmd got isr=%h cnt=%0d exp 3/2", isr_data, isr_count);
    end
    checks++;
  endtask

  task automatic test_priority_and_hold();
    do_reset();
    drive_in(32'hFF, 8, 1'b0);
    push_cmd = 1'b1; mov_valid = 1'b1; mov_data = 32'hCAFEF00D;
    @(negedge clk);
    if (push_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL prio_outputs got pv=%b st=%b exp 0/0", push_valid, stall);
    end
    checks++;
    tick();
    if (isr_data !== 32'hCAFEF00D || isr_count !== 6'd0) begin
      failures++; $display("FAIL prio_mov got isr=%h cnt=%0d exp cafef00d/0", isr_data, isr_count);
    end
    checks++;
    drive_in(32'hFF, 0, 1'b0);
    autopush_en = 1'b1; penable = 1'b0;
    @(negedge clk);
    if (push_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL hold_outputs got pv=%b st=%b exp 0/0", push_valid, stall);
    end
    checks++;
    tick();
    drive_idle();
    if (isr_data !== 32'hCAFEF00D || isr_count !== 6'd0) begin
      failures++; $display("FAIL hold_state got isr=%h cnt=%0d exp cafef00d/0", isr_data, isr_count);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [31:0] m_isr, n_isr, e_pd, nx;
    int m_cnt, n_cnt, n, t, nc;
    bit m_ovf, n_ovf, e_pv, e_st;
    do_reset();
    m_isr = '0; m_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      penable      = ($urandom_range(0, 9) != 0);
      in_valid     = ($urandom_range(0, 2) != 0);
      push_cmd     = ($urandom_range(0, 4) == 0);
      mov_valid    = ($urandom_range(0, 9) == 0);
      in_data      = $urandom;
      mov_data     = $urandom;
      in_count     = 5'($urandom_range(0, 31));
      shift_right  = 1'($urandom_range(0, 1));
      autopush_en  = 1'($urandom_range(0, 1));
      push_thresh  = 5'($urandom_range(0, 31));
      push_if_full = 1'($urandom_range(0, 1));
      push_block   = 1'($urandom_range(0, 1));
      push_ready   = ($urandom_range(0, 3) != 0);
      ovf_clr      = ($urandom_range(0, 7) == 0);

      e_pv = 0; e_st = 0; e_pd = '0;
      n_isr = m_isr; n_cnt = m_cnt; n_ovf = m_ovf;
      t = (push_thresh == 0) ? 32 : int'(push_thresh);
      if (penable) begin
        if (ovf_clr) n_ovf = 0;
        if (mov_valid) begin
          n_isr = mov_data; n_cnt = 0;
        end else if (push_cmd) begin
          if (push_if_full && m_cnt < t) begin
          end else if (push_ready) begin
            e_pv = 1; e_pd = m_isr; n_isr = '0; n_cnt = 0;
          end else if (push_block) begin
            e_st = 1;
          end else begin
            n_isr = '0; n_cnt = 0; n_ovf = 1;
          end
        end else if (in_valid) begin
          n  = (in_count == 0) ? 32 : int'(in_count);
          nx = m_shift(m_isr, in_data, n, shift_right);
          nc = (m_cnt + n > 32) ? 32 : m_cnt + n;
          if (autopush_en && nc >= t) begin
            if (push_ready) begin
              e_pv = 1; e_pd = nx; n_isr = '0; n_cnt = 0;
            end else begin
              e_st = 1;
            end
          end else begin
            n_isr = nx; n_cnt = nc;
          end
        end
      end

      @(negedge clk);
      if (push_valid !== e_pv) begin failures++; $display("FAIL rnd_pv[%0d] got=%b exp=%b", i, push_valid, e_pv); end
      checks++;
      if (e_pv && push_data !== e_pd) begin failures++; $display("FAIL rnd_pd[%0d] got=%h exp=%h", i, push_data, e_pd); end
      checks++;
      if (stall !== e_st) begin failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall, e_st); end
      checks++;
      tick();
      if (isr_data !== n_isr) begin failures++; $display("FAIL rnd_isr[%0d] got=%h exp=%h", i, isr_data, n_isr); end
      checks++;
      if (isr_count !== 6'(n_cnt)) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, isr_count, n_cnt); end
      checks++;
      if (overflow !== n_ovf) begin failures++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, overflow, n_ovf); end
      checks++;
      m_isr = n_isr; m_cnt = n_cnt; m_ovf = n_ovf;
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_left_saturate();
    test_right();
    test_autopush(1'b0);
    test_autopush(1'b1);
    test_nb_push_overflow();
    test_iffull_then_reset();
    test_priority_and_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
